// File: rtl/traffic_pkg.sv
// Shared state codes, lamp codes and road encoding for the intersection scheduler.
package traffic_pkg;

   localparam logic [2:0] ST_NS_GREEN  = 3'd0;
   localparam logic [2:0] ST_NS_YELLOW = 3'd1;
   localparam logic [2:0] ST_ALLRED_NS = 3'd2;
   localparam logic [2:0] ST_EW_GREEN  = 3'd3;
   localparam logic [2:0] ST_EW_YELLOW = 3'd4;
   localparam logic [2:0] ST_ALLRED_EW = 3'd5;
   localparam logic [2:0] ST_PED_WALK  = 3'd6;

   typedef enum logic [2:0] {
      NS_GREEN  = ST_NS_GREEN,
      NS_YELLOW = ST_NS_YELLOW,
      ALLRED_NS = ST_ALLRED_NS,
      EW_GREEN  = ST_EW_GREEN,
      EW_YELLOW = ST_EW_YELLOW,
      ALLRED_EW = ST_ALLRED_EW,
      PED_WALK  = ST_PED_WALK
   } phase_t;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   localparam logic ROAD_NS = 1'b0;
   localparam logic ROAD_EW = 1'b1;

endpackage

// File: rtl/phase_timer.sv
// Tick-enabled, saturating phase counter; cleared whenever the phase changes.
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             tick,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (tick && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/intersection_scheduler.sv
// Phase sequencer for a two-road intersection with a pedestrian walk phase.
//
// state      | meaning
// NS_GREEN   | NS moving; leaves on gap-out/max-out once EW or ped demand exists
// NS_YELLOW  | NS clearing, YELLOW_T ticks
// ALLRED_NS  | clearance after NS, ALLRED_T ticks; then walk or EW green
// EW_GREEN   | EW moving; mirror of NS_GREEN
// EW_YELLOW  | EW clearing, YELLOW_T ticks
// ALLRED_EW  | clearance after EW, ALLRED_T ticks; then walk or NS green
// PED_WALK   | all roads red, walk lamp on, WALK_T ticks
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 10,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int WALK_T    = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       car_ns,
   input  logic       car_ew,
   input  logic       ped_btn,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic       ped_wait,
   output logic [2:0] phase
);

   localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);

   phase_t           state;
   logic [CNT_W-1:0] cnt;
   logic             leave;
   logic             ped_pend;
   logic             btn_q;
   logic             last_green;
   logic             ped_rise;

   assign ped_rise = ped_btn & ~btn_q;

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (leave),
      .tick    (tick),
      .cnt     (cnt)
   );

   // Every exit is a real state change, so this also clears the timer.
   always_comb begin
      leave = 1'b0;
      case (state)
         NS_GREEN:  leave = tick && (cnt >= GMIN_LAST) && (car_ew || ped_pend)
                            && (!car_ns || (cnt >= GMAX_LAST));
         EW_GREEN:  leave = tick && (cnt >= GMIN_LAST) && (car_ns || ped_pend)
                            && (!car_ew || (cnt >= GMAX_LAST));
         NS_YELLOW,
         EW_YELLOW: leave = tick && (cnt == YEL_LAST);
         ALLRED_NS,
         ALLRED_EW: leave = tick && (cnt == AR_LAST);
         PED_WALK:  leave = tick && (cnt == WALK_LAST);
         default:   leave = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= NS_GREEN;
         ped_pend   <= 1'b0;
         btn_q      <= 1'b0;
         last_green <= ROAD_NS;
      end else begin
         btn_q <= ped_btn;
         if (leave) begin
            case (state)
               NS_GREEN: begin
                  state      <= NS_YELLOW;
                  last_green <= ROAD_NS;
               end
               NS_YELLOW: state <= ALLRED_NS;
               ALLRED_NS: state <= ped_pend ? PED_WALK : EW_GREEN;
               EW_GREEN: begin
                  state      <= EW_YELLOW;
                  last_green <= ROAD_EW;
               end
               EW_YELLOW: state <= ALLRED_EW;
               ALLRED_EW: state <= ped_pend ? PED_WALK : NS_GREEN;
               PED_WALK:  state <= (last_green == ROAD_NS) ? EW_GREEN : NS_GREEN;
               default:   state <= NS_GREEN;
            endcase
         end
         // Entering the walk clears the request even if a new press lands on the same edge.
         if (leave && ped_pend && ((state == ALLRED_NS) || (state == ALLRED_EW))) begin
            ped_pend <= 1'b0;
         end else if (ped_rise && (state != PED_WALK)) begin
            ped_pend <= 1'b1;
         end
      end
   end

   always_comb begin
      ns_light = LAMP_RED;
      ew_light = LAMP_RED;
      walk     = 1'b0;
      case (state)
         NS_GREEN:  ns_light = LAMP_GRN;
         NS_YELLOW: ns_light = LAMP_YEL;
         EW_GREEN:  ew_light = LAMP_GRN;
         EW_YELLOW: ew_light = LAMP_YEL;
         PED_WALK:  walk     = 1'b1;
         default: ;
      endcase
   end

   assign ped_wait = ped_pend;
   assign phase    = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Randomized and directed bench for intersection_scheduler against a phase/duration model.
module tb_intersection_scheduler;

   localparam int CNT_W     = 8;
   localparam int GREEN_MIN = 4;
   localparam int GREEN_MAX = 10;
   localparam int YELLOW_T  = 2;
   localparam int ALLRED_T  = 1;
   localparam int WALK_T    = 5;

   logic       clk = 1'b0;
   logic       reset_n, tick, car_ns, car_ew, ped_btn;
   logic [2:0] ns_light, ew_light, phase;
   logic       walk, ped_wait;

   always #5 clk = ~clk;

   intersection_scheduler #(
      .CNT_W(CNT_W), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
      .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
   ) dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .car_ns(car_ns), .car_ew(car_ew),
      .ped_btn(ped_btn), .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
      .ped_wait(ped_wait), .phase(phase)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: phase index 0..6, ticks spent in the phase (unbounded), pending request.
   int m_ph, m_el;
   bit m_pend, m_bq, m_lg;

   function automatic int fixed_dur(input int ph);
      case (ph)
         1, 4:    return YELLOW_T;
         2, 5:    return ALLRED_T;
         default: return WALK_T;
      endcase
   endfunction

   function automatic logic [6:0] lamps(input int ph);
      case (ph)
         0:       return {3'b001, 3'b100, 1'b0};
         1:       return {3'b010, 3'b100, 1'b0};
         3:       return {3'b100, 3'b001, 1'b0};
         4:       return {3'b100, 3'b010, 1'b0};
         6:       return {3'b100, 3'b100, 1'b1};
         default: return {3'b100, 3'b100, 1'b0};
      endcase
   endfunction

   task automatic model_step(input bit r, input bit t, input bit cns, input bit cew, input bit btn);
      int nxt;
      bit rise;
      if (!r) begin
         m_ph = 0; m_el = 0; m_pend = 0; m_bq = 0; m_lg = 0;
      end else begin
         rise = btn && !m_bq;
         nxt  = m_ph;
         if (m_ph == 0 || m_ph == 3) begin
            bit own   = (m_ph == 0) ? cns : cew;
            bit other = (m_ph == 0) ? cew : cns;
            if (t && m_el >= GREEN_MIN - 1 && (other || m_pend) && (!own || m_el >= GREEN_MAX - 1)) begin
               nxt  = m_ph + 1;
               m_lg = (m_ph == 3);
            end
         end else if (t && m_el == fixed_dur(m_ph) - 1) begin
            case (m_ph)
               1:       nxt = 2;
               4:       nxt = 5;
               2:       nxt = m_pend ? 6 : 3;
               5:       nxt = m_pend ? 6 : 0;
               default: nxt = m_lg ? 0 : 3;
            endcase
         end
         if (nxt == 6 && m_ph != 6) m_pend = 0;
         else if (rise && m_ph != 6) m_pend = 1;
         if (nxt != m_ph) m_el = 0;
         else if (t) m_el++;
         m_bq = btn;
         m_ph = nxt;
      end
   endtask

   logic [2:0] pre_phase;
   int         walk_cycles;

   task automatic cyc(input bit r, input bit t, input bit cns, input bit cew, input bit btn);
      reset_n = r; tick = t; car_ns = cns; car_ew = cew; ped_btn = btn;
      pre_phase = phase;
      @(posedge clk);
      model_step(r, t, cns, cew, btn);
      #1;
      if (walk) walk_cycles++;
      check("outputs", 32'({ns_light, ew_light, walk, ped_wait, phase}),
            32'({lamps(m_ph), m_pend, 3'(m_ph)}));
   endtask

   task automatic do_reset();
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
   endtask

   // Counts clk edges spent in NS_GREEN after reset release.
   task automatic measure(input string tag, input bit cns, input bit cew, input int period,
                          input int exp_cycles);
      int n = 0;
      do_reset();
      for (int i = 0; i < 200; i++) begin
         cyc(1, (i % period) == period - 1, cns, cew, 0);
         if (pre_phase == 3'd0) n++;
         if (phase != 3'd0) break;
      end
      check(tag, 32'(n), 32'(exp_cycles));
   endtask

   initial begin
      int pns, pew, len;
      bit tmode, btn;

      do_reset();
      for (int i = 0; i < 30; i++) cyc(1, 1, 0, 0, 0);
      check("rest_phase", 32'(phase), 32'd0);

      measure("gapout_len", 0, 1, 1, 4);
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 0);
      check("gapout_ew_green", 32'(ew_light), 32'b001);
      measure("maxout_len", 1, 1, 1, 10);
      for (int i = 0; i < 60; i++) cyc(1, 1, 1, 1, 0);
      measure("tickgate_len", 0, 1, 3, 12);

      // Pedestrian press, then presses during walk that must be ignored.
      do_reset();
      walk_cycles = 0;
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 1);
      check("ped_wait_set", 32'(ped_wait), 32'd1);
      for (int i = 0; i < 40 && phase != 3'd6; i++) cyc(1, 1, 0, 0, 0);
      check("walk_entered", 32'(phase), 32'd6);
      cyc(1, 1, 0, 0, 1);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 1);
      cyc(1, 1, 0, 0, 0);
      check("walk_press_ignored", 32'(ped_wait), 32'd0);
      for (int i = 0; i < 30; i++) cyc(1, 1, 0, 0, 0);
      check("single_walk", 32'(walk_cycles), 32'(WALK_T));
      check("after_walk_ew", 32'(phase), 32'd3);

      // Reset inside yellow and inside walk.
      do_reset();
      for (int i = 0; i < 40 && phase != 3'd1; i++) cyc(1, 1, 0, 1, 0);
      cyc(0, 1, 0, 1, 0);
      check("rst_in_yellow", 32'(ns_light), 32'b001);
      cyc(1, 1, 0, 0, 1);
      for (int i = 0; i < 40 && phase != 3'd6; i++) cyc(1, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      check("rst_in_walk", 32'({walk, ped_wait, phase}), 32'd0);

      // Random segments of car demand, button activity and tick density.
      btn = 0;
      for (int s = 0; s < 80; s++) begin
         pns   = $urandom_range(0, 100);
         pew   = $urandom_range(0, 100);
         tmode = $urandom_range(0, 1);
         len   = $urandom_range(10, 60);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 9) == 0) btn = ~btn;
            cyc($urandom_range(0, 299) != 0,
                tmode ? 1'b1 : ($urandom_range(0, 2) == 0),
                $urandom_range(0, 99) < pns,
                $urandom_range(0, 99) < pew,
                btn);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
